// File: rtl/ahb_mux_s2m_p_if.sv
// ahb_mux_s2m_p_if
//   Bundles the AHB slave-to-master multiplexer signals.
//   Address-phase request from the master side : HTRANS, HSEL
//   Per-slave data-phase returns               : HRDATA_S, HREADYOUT_S, HRESP_S
//   Muxed data-phase result back to the master : HREADY, HRESP, HRDATA
//   Diagnostic pulse                           : MSEL_ERR
//   master modport : the side that drives the request and slave returns
//   slave modport  : the multiplexer itself
interface ahb_mux_s2m_p_if #(
  parameter int NSLV = 8,
  parameter int DW   = 32
);
  logic [1:0]         HTRANS;
  logic [NSLV-1:0]    HSEL;
  logic [NSLV*DW-1:0] HRDATA_S;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [2*NSLV-1:0]  HRESP_S;
  logic               HREADY;
  logic [1:0]         HRESP;
  logic [DW-1:0]      HRDATA;
  logic               MSEL_ERR;

  modport master (
    output HTRANS, HSEL, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HREADY, HRESP, HRDATA, MSEL_ERR
  );

  modport slave (
    input  HTRANS, HSEL, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HREADY, HRESP, HRDATA, MSEL_ERR
  );
endinterface

// File: rtl/ahb_mux_s2m_p.sv
// ahb_mux_s2m_p
//   AHB slave-to-master response multiplexer with a built-in default slave.
//   The address phase is registered whenever HREADY is high; the registered
//   one-hot selection then steers one slave's HRDATA/HREADYOUT/HRESP back to
//   the master combinationally. Unmapped or multiply-selected transfers are
//   answered by an internal default slave with a two-cycle ERROR response.
// Ports
//   HCLK    : clock, all state changes on the rising edge
//   HRESETn : asynchronous active-low reset
//   bus     : ahb_mux_s2m_p_if.slave (request in, muxed response out)
module ahb_mux_s2m_p #(
  parameter int NSLV = 8,
  parameter int DW   = 32
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_mux_s2m_p_if.slave  bus
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  ds_state_t       state_r;
  logic [NSLV-1:0] sel_r;       // one-hot data-phase slave selection
  logic            dflt_r;      // data phase owned by the default slave
  logic            msel_err_r;

  logic            trans_s;
  logic            none_s;
  logic            multi_s;
  logic            addr_err_s;
  logic [DW-1:0]   rd_mux_s;
  logic            rdy_mux_s;
  logic [1:0]      resp_mux_s;
  logic            hready_s;
  logic [1:0]      hresp_s;
  logic [DW-1:0]   hrdata_s;

  // True when more than one bit is set: clearing the lowest set bit leaves something.
  function automatic logic multi_hot(input logic [NSLV-1:0] v);
    return |(v & (v - NSLV'(1)));
  endfunction

  // Address-phase classification; BUSY and IDLE share HTRANS[1]==0.
  always_comb begin
    trans_s    = bus.HTRANS[1];
    none_s     = (bus.HSEL == {NSLV{1'b0}});
    multi_s    = multi_hot(bus.HSEL);
    addr_err_s = trans_s & (none_s | multi_s);
  end

  // AND-OR slave mux: an all-zero selection yields all-zero results.
  always_comb begin
    rd_mux_s   = {DW{1'b0}};
    rdy_mux_s  = 1'b0;
    resp_mux_s = 2'b00;
    for (int i = 0; i < NSLV; i++) begin
      rd_mux_s   = rd_mux_s   | (bus.HRDATA_S[i*DW +: DW] & {DW{sel_r[i]}});
      rdy_mux_s  = rdy_mux_s  | (bus.HREADYOUT_S[i] & sel_r[i]);
      resp_mux_s = resp_mux_s | (bus.HRESP_S[2*i +: 2] & {2{sel_r[i]}});
    end
  end

  // Data-phase response: default slave, routed slave, or zero-wait OKAY.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 2'b00;
    hrdata_s = {DW{1'b0}};
    if (dflt_r) begin
      // First error cycle stalls, second completes the ERROR.
      hready_s = (state_r == DS_ERR2);
      hresp_s  = 2'b01;
    end else if (|sel_r) begin
      hready_s = rdy_mux_s;
      hresp_s  = resp_mux_s;
      hrdata_s = rd_mux_s;
    end else begin
      hready_s = 1'b1;
      hresp_s  = 2'b00;
    end
  end

  assign bus.HREADY   = hready_s;
  assign bus.HRESP    = hresp_s;
  assign bus.HRDATA   = hrdata_s;
  assign bus.MSEL_ERR = msel_err_r;

  // Default-slave FSM together with the address-phase sampling registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r    <= DS_IDLE;
      sel_r      <= {NSLV{1'b0}};
      dflt_r     <= 1'b0;
      msel_err_r <= 1'b0;
    end else begin
      msel_err_r <= 1'b0;
      case (state_r)
        DS_IDLE, DS_ERR2: begin
          // DS_ERR2 always has HREADY high, so it samples like DS_IDLE.
          if (hready_s) begin
            msel_err_r <= trans_s & multi_s;
            if (addr_err_s) begin
              state_r <= DS_ERR1;
              sel_r   <= {NSLV{1'b0}};
              dflt_r  <= 1'b1;
            end else begin
              state_r <= DS_IDLE;
              sel_r   <= trans_s ? bus.HSEL : {NSLV{1'b0}};
              dflt_r  <= 1'b0;
            end
          end else begin
            state_r <= state_r;
            sel_r   <= sel_r;
            dflt_r  <= dflt_r;
          end
        end
        DS_ERR1: begin
          state_r <= DS_ERR2;
        end
        default: begin
          state_r <= DS_IDLE;
          sel_r   <= {NSLV{1'b0}};
          dflt_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mux_s2m_p.sv
// tb_ahb_mux_s2m_p
//   Drives one shared stimulus into three multiplexer instances
//   (8x32, 16x64, 1x32) and compares each against a transaction-level
//   model: an error sample yields "stall, then complete" with ERROR,
//   a single selected slave is passed straight through, anything else
//   is a zero-wait OKAY with zero data.
module tb_ahb_mux_s2m_p;

  typedef struct packed {
    logic        ready;
    logic [1:0]  resp;
    logic [63:0] data;
    logic        msel;
  } exp_t;

  logic          HCLK;
  logic          HRESETn;
  logic [1:0]    htrans;
  logic [15:0]   hsel_w;
  logic [1023:0] hrdata_w;
  logic [15:0]   hrdy_w;
  logic [31:0]   hresp_w;

  int checks   = 0;
  int failures = 0;

  // Model state: remaining error cycles, selected slave (-1 none), pending MSEL pulse.
  int   m_err  [3] = '{0, 0, 0};
  int   m_sel  [3] = '{-1, -1, -1};
  logic m_msel [3] = '{1'b0, 1'b0, 1'b0};

  logic        obs_ready [3];
  logic [1:0]  obs_resp  [3];
  logic [63:0] obs_data  [3];
  logic        obs_msel  [3];

  ahb_mux_s2m_p_if #(.NSLV(8),  .DW(32)) if8  ();
  ahb_mux_s2m_p_if #(.NSLV(16), .DW(64)) if16 ();
  ahb_mux_s2m_p_if #(.NSLV(1),  .DW(32)) if1  ();

  ahb_mux_s2m_p #(.NSLV(8),  .DW(32)) u_dut8  (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if8));
  ahb_mux_s2m_p #(.NSLV(16), .DW(64)) u_dut16 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if16));
  ahb_mux_s2m_p #(.NSLV(1),  .DW(32)) u_dut1  (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if1));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // 32-bit instances see the low half of each 64-bit slave word.
  logic [255:0] hrdata8;
  always_comb begin
    hrdata8 = '0;
    for (int i = 0; i < 8; i++) hrdata8[i*32 +: 32] = hrdata_w[i*64 +: 32];
  end

  assign if8.HTRANS       = htrans;
  assign if8.HSEL         = hsel_w[7:0];
  assign if8.HRDATA_S     = hrdata8;
  assign if8.HREADYOUT_S  = hrdy_w[7:0];
  assign if8.HRESP_S      = hresp_w[15:0];
  assign if16.HTRANS      = htrans;
  assign if16.HSEL        = hsel_w;
  assign if16.HRDATA_S    = hrdata_w;
  assign if16.HREADYOUT_S = hrdy_w;
  assign if16.HRESP_S     = hresp_w;
  assign if1.HTRANS       = htrans;
  assign if1.HSEL         = hsel_w[0:0];
  assign if1.HRDATA_S     = hrdata_w[31:0];
  assign if1.HREADYOUT_S  = hrdy_w[0:0];
  assign if1.HRESP_S      = hresp_w[1:0];

  always_comb begin
    obs_ready[0] = if8.HREADY;  obs_resp[0] = if8.HRESP;
    obs_data[0]  = {32'h0, if8.HRDATA};  obs_msel[0] = if8.MSEL_ERR;
    obs_ready[1] = if16.HREADY; obs_resp[1] = if16.HRESP;
    obs_data[1]  = if16.HRDATA;          obs_msel[1] = if16.MSEL_ERR;
    obs_ready[2] = if1.HREADY;  obs_resp[2] = if1.HRESP;
    obs_data[2]  = {32'h0, if1.HRDATA};  obs_msel[2] = if1.MSEL_ERR;
  end

  function automatic int nslv_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 16 : 1);
  endfunction

  // -1 idle/busy, -2 unmapped, -3 multiple, otherwise the selected slave.
  function automatic int classify(input int k);
    logic [15:0] hs;
    hs = 16'h0;
    for (int i = 0; i < nslv_of(k); i++) hs[i] = hsel_w[i];
    if (htrans[1] == 1'b0) return -1;
    if ($countones(hs) == 0) return -2;
    if ($countones(hs) > 1) return -3;
    for (int i = 0; i < 16; i++) if (hs[i]) return i;
    return -2;
  endfunction

  function automatic exp_t exp_of(input int k);
    exp_t e;
    int   s;
    e.ready = 1'b1;
    e.resp  = 2'b00;
    e.data  = 64'h0;
    e.msel  = m_msel[k];
    if (m_err[k] == 2) begin
      e.ready = 1'b0;
      e.resp  = 2'b01;
    end else if (m_err[k] == 1) begin
      e.resp  = 2'b01;
    end else if (m_sel[k] >= 0) begin
      s       = m_sel[k];
      e.ready = hrdy_w[s];
      e.resp  = hresp_w[2*s +: 2];
      e.data  = hrdata_w[s*64 +: 64];
      if (k != 1) e.data[63:32] = 32'h0;
    end
    return e;
  endfunction

  function automatic logic model_ready(input int k);
    exp_t e;
    e = exp_of(k);
    return e.ready;
  endfunction

  // Reference model advance: a completed cycle accepts a new address phase.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 0; k < 3; k++) begin
        m_err[k]  <= 0;
        m_sel[k]  <= -1;
        m_msel[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_msel[k] <= 1'b0;
        if (model_ready(k)) begin
          if (classify(k) <= -2) begin
            m_err[k]  <= 2;
            m_sel[k]  <= -1;
            m_msel[k] <= (classify(k) == -3);
          end else begin
            m_err[k]  <= 0;
            m_sel[k]  <= classify(k);
          end
        end else if (m_err[k] == 2) begin
          m_err[k] <= 1;
        end
      end
    end
  end

  task automatic bus_defaults();
    htrans  = 2'b00;
    hsel_w  = 16'h0;
    hrdy_w  = 16'hFFFF;
    hresp_w = 32'h0;
    for (int i = 0; i < 32; i++) hrdata_w[i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus_defaults();
    htrans = 2'b10;
    hsel_w = 16'h0012;
    repeat (2) @(negedge HCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== {1'b1, 2'b00, 64'h0, 1'b0}) begin
        failures++;
        $display("FAIL reset dut%0d: got rdy=%b resp=%b data=%h msel=%b, want 1/00/0/0",
                 k, obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]);
      end
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus_defaults();
  endtask

  task automatic test_single_read();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      @(negedge HCLK);
      if (s == 0) begin
        bus_defaults();
        htrans = 2'b10;
        hsel_w = 16'h0004;
        hrdata_w[2*64 +: 64] = 64'h5A5A0F0F_A5A5A5A5;
      end else begin
        htrans = 2'b00;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_of(k);
        checks++;
        if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== e) begin
          failures++;
          $display("FAIL single_read dut%0d step%0d: got %b/%b/%h/%b want %b/%b/%h/%b", k, s,
                   obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k], e.ready, e.resp, e.data, e.msel);
        end
      end
      if (s == 1) begin
        checks++;
        if ({obs_ready[0], obs_resp[0], obs_data[0]} !== {1'b1, 2'b00, 64'hA5A5A5A5}) begin
          failures++;
          $display("FAIL single_read_lit: got %b/%b/%h want 1/00/a5a5a5a5", obs_ready[0], obs_resp[0], obs_data[0]);
        end
      end
    end
  endtask

  task automatic test_wait_hold();
    exp_t        e;
    logic        w_rdy;
    logic [63:0] w_data;
    for (int s = 0; s < 6; s++) begin
      @(negedge HCLK);
      case (s)
        0: begin
          bus_defaults();
          htrans = 2'b10;
          hsel_w = 16'h0020;
          hrdata_w[5*64 +: 64] = 64'hFEED0005_55550005;
          hrdata_w[1*64 +: 64] = 64'hBEEF0001_11110001;
        end
        1, 2, 3: begin
          hrdy_w[5] = 1'b0;
          hsel_w    = 16'h0002;
        end
        4: hrdy_w[5] = 1'b1;
        default: htrans = 2'b00;
      endcase
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_of(k);
        checks++;
        if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== e) begin
          failures++;
          $display("FAIL wait_hold dut%0d step%0d: got %b/%b/%h/%b want %b/%b/%h/%b", k, s,
                   obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k], e.ready, e.resp, e.data, e.msel);
        end
      end
      if (s >= 1) begin
        w_rdy  = (s >= 4);
        w_data = (s == 5) ? 64'h11110001 : 64'h55550005;
        checks++;
        if ({obs_ready[0], obs_data[0]} !== {w_rdy, w_data}) begin
          failures++;
          $display("FAIL wait_hold_lit step%0d: got rdy=%b data=%h want rdy=%b data=%h",
                   s, obs_ready[0], obs_data[0], w_rdy, w_data);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    exp_t       e;
    logic [2:0] w_lit;
    for (int s = 0; s < 6; s++) begin
      @(negedge HCLK);
      if (s == 0 || s == 2) begin
        if (s == 0) bus_defaults();
        htrans = 2'b10;
        hsel_w = 16'h0000;
      end else begin
        htrans = 2'b00;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_of(k);
        checks++;
        if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== e) begin
          failures++;
          $display("FAIL unmapped dut%0d step%0d: got %b/%b/%h/%b want %b/%b/%h/%b", k, s,
                   obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k], e.ready, e.resp, e.data, e.msel);
        end
      end
      if (s >= 1) begin
        case (s)
          1, 3:    w_lit = 3'b0_01;
          2, 4:    w_lit = 3'b1_01;
          default: w_lit = 3'b1_00;
        endcase
        checks++;
        if ({obs_ready[0], obs_resp[0], obs_data[0], obs_msel[0]} !== {w_lit, 64'h0, 1'b0}) begin
          failures++;
          $display("FAIL unmapped_lit step%0d: got rdy/resp=%b%b data=%h msel=%b want %b data=0 msel=0",
                   s, obs_ready[0], obs_resp[0], obs_data[0], obs_msel[0], w_lit);
        end
      end
    end
  endtask

  task automatic test_multi();
    exp_t       e;
    logic [3:0] w_lit;
    for (int s = 0; s < 4; s++) begin
      @(negedge HCLK);
      if (s == 0) begin
        bus_defaults();
        htrans = 2'b10;
        hsel_w = 16'h0012;
        hrdata_w[1*64 +: 64] = 64'h0123456789ABCDEF;
        hrdata_w[4*64 +: 64] = 64'hFFFFFFFFFFFFFFFF;
      end else begin
        htrans = 2'b00;
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_of(k);
        checks++;
        if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== e) begin
          failures++;
          $display("FAIL multi dut%0d step%0d: got %b/%b/%h/%b want %b/%b/%h/%b", k, s,
                   obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k], e.ready, e.resp, e.data, e.msel);
        end
      end
      if (s >= 1) begin
        case (s)
          1:       w_lit = 4'b1_0_01;
          2:       w_lit = 4'b0_1_01;
          default: w_lit = 4'b0_1_00;
        endcase
        checks++;
        if ({obs_msel[0], obs_ready[0], obs_resp[0], obs_data[0]} !== {w_lit, 64'h0}) begin
          failures++;
          $display("FAIL multi_lit step%0d: got msel/rdy/resp=%b%b%b data=%h want %b data=0",
                   s, obs_msel[0], obs_ready[0], obs_resp[0], obs_data[0], w_lit);
        end
      end
    end
  endtask

  task automatic test_idle_busy();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      @(negedge HCLK);
      if (s == 0) bus_defaults();
      hsel_w = 16'h0001;
      hrdata_w[63:0] = 64'hDEADBEEF_CAFEF00D;
      htrans = (s == 1) ? 2'b01 : 2'b00;
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_of(k);
        checks++;
        if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== e) begin
          failures++;
          $display("FAIL idle_busy dut%0d step%0d: got %b/%b/%h/%b want %b/%b/%h/%b", k, s,
                   obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k], e.ready, e.resp, e.data, e.msel);
        end
      end
      if (s >= 1) begin
        checks++;
        if ({obs_ready[0], obs_resp[0], obs_data[0]} !== {1'b1, 2'b00, 64'h0}) begin
          failures++;
          $display("FAIL idle_busy_lit step%0d: got %b/%b/%h want 1/00/0", s, obs_ready[0], obs_resp[0], obs_data[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_error();
    @(negedge HCLK);
    bus_defaults();
    htrans = 2'b10;
    hsel_w = 16'h0000;
    @(negedge HCLK);
    htrans = 2'b00;
    #1;
    checks++;
    if ({obs_ready[0], obs_resp[0]} !== 3'b0_01) begin
      failures++;
      $display("FAIL rst_err_pre: got rdy=%b resp=%b want 0/01", obs_ready[0], obs_resp[0]);
    end
    HRESETn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== {1'b1, 2'b00, 64'h0, 1'b0}) begin
        failures++;
        $display("FAIL rst_err_async dut%0d: got %b/%b/%h/%b want 1/00/0/0",
                 k, obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]);
      end
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    htrans  = 2'b10;
    hsel_w  = 16'h0008;
    hrdata_w[3*64 +: 64] = 64'h33333333_3C3C3C3C;
    @(negedge HCLK);
    htrans = 2'b00;
    #1;
    checks++;
    if ({obs_ready[0], obs_resp[0], obs_data[0]} !== {1'b1, 2'b00, 64'h3C3C3C3C}) begin
      failures++;
      $display("FAIL rst_err_after: got %b/%b/%h want 1/00/3c3c3c3c", obs_ready[0], obs_resp[0], obs_data[0]);
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int s = 0; s < 400; s++) begin
      @(negedge HCLK);
      htrans = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       hsel_w = 16'h0;
        1:       hsel_w = 16'h1 << $urandom_range(0, 15);
        2:       hsel_w = 16'($urandom);
        default: hsel_w = 16'h1 << $urandom_range(0, 7);
      endcase
      for (int i = 0; i < 16; i++) begin
        hrdy_w[i]          = ($urandom_range(0, 4) != 0);
        hresp_w[2*i +: 2]  = {1'b0, 1'($urandom_range(0, 1))};
      end
      for (int i = 0; i < 32; i++) hrdata_w[i*32 +: 32] = $urandom;
      #1;
      for (int k = 0; k < 3; k++) begin
        e = exp_of(k);
        checks++;
        if ({obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k]} !== e) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d: got %b/%b/%h/%b want %b/%b/%h/%b", k, s,
                   obs_ready[k], obs_resp[k], obs_data[k], obs_msel[k], e.ready, e.resp, e.data, e.msel);
        end
      end
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    bus_defaults();
    test_reset();
    test_single_read();
    test_wait_hold();
    test_unmapped();
    test_multi();
    test_idle_busy();
    test_reset_mid_error();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_mux_s2m_p.md
AHB_MUX_S2M_P -- requirements
Module: ahb_mux_s2m_p

Interface
REQ-001 SHALL provide parameter NSLV, default 8, meaning number of external slaves (legal range 1..16).
REQ-002 SHALL provide parameter DW, default 32, meaning read-data width in bits (legal values 32 or 64).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port HCLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port HRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port HTRANS, input, 2 bits: address-phase transfer type from the master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL have port HSEL, input, NSLV bits: decoder select, bit i selects slave i.
REQ-008 SHALL have port HRDATA_S, input, NSLV*DW bits: slave i read data in bits [i*DW +: DW].
REQ-009 SHALL have port HREADYOUT_S, input, NSLV bits: slave i ready.
REQ-010 SHALL have port HRESP_S, input, 2*NSLV bits: slave i response in bits [2i +: 2] (00 OKAY, 01 ERROR).
REQ-011 SHALL have port HREADY, output, 1 bit: muxed ready to master and to all slaves.
REQ-012 SHALL have port HRESP, output, 2 bits: muxed response.
REQ-013 SHALL have port HRDATA, output, DW bits: muxed read data.
REQ-014 SHALL have port MSEL_ERR, output, 1 bit: one-cycle pulse flagging a multiple-select address phase.

Function
REQ-015 SHALL sample the address phase on a rising HCLK edge only when HREADY==1; while HREADY==0, the data-phase selection and the FSM SHALL hold.
REQ-016 SHALL classify each sampled phase: HTRANS[1]==0 -> IDLE_OK; HTRANS[1]==1 with exactly one HSEL bit set -> SLAVE(i); HTRANS[1]==1 with zero bits set -> UNMAPPED; HTRANS[1]==1 with two or more bits set -> MULTI.
REQ-017 SHALL drive, for SLAVE(i) in the data phase, HRDATA=slice i of HRDATA_S, HREADY=HREADYOUT_S[i] and HRESP=HRESP_S slice i, all combinationally with no added latency.
REQ-018 SHALL drive, for IDLE_OK in the data phase, HREADY=1, HRESP=00 and HRDATA=0 (zero-wait OKAY).
REQ-019 SHALL run an internal default-slave FSM with states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-020 SHALL, on an UNMAPPED or MULTI sample, move the FSM DS_IDLE->DS_ERR1.
REQ-021 SHALL, in DS_ERR1, drive HREADY=0, HRESP=01 and HRDATA=0, then move unconditionally to DS_ERR2.
REQ-022 SHALL, in DS_ERR2, drive HREADY=1, HRESP=01 and HRDATA=0.
REQ-023 SHALL, at the DS_ERR2 edge, move the FSM to DS_ERR1 if the next sample is UNMAPPED or MULTI, and otherwise to DS_IDLE with the new selection loaded in the same edge.
REQ-024 SHALL pulse MSEL_ERR high for exactly the one cycle following a MULTI sample; an UNMAPPED sample SHALL NOT assert it.
REQ-025 SHALL give a MULTI sample the same response as UNMAPPED and SHALL route no external slave.
REQ-026 SHALL hold the selection register as NSLV-bit one-hot plus a default flag; the mux SHALL be AND-OR, so an all-zero selection yields HRDATA=0.
REQ-027 SHALL treat BUSY (01) as IDLE_OK.
REQ-028 SHALL ignore any HSEL or HTRANS change while HREADY==0 until the cycle in which HREADY returns to 1.
REQ-029 SHALL make the RTL size with NSLV and DW only, with no per-slave hand-written code.

Reset
REQ-030 SHALL, while HRESETn==0, asynchronously force the selection to IDLE_OK and the FSM to DS_IDLE, giving HREADY=1, HRESP=00, HRDATA=0 and MSEL_ERR=0.
REQ-031 SHALL, if reset asserts mid-wait or mid-error, abandon the transfer; the first sample after reset release SHALL be taken on the first rising edge with HRESETn==1.

Verification
REQ-032 SHALL cover: NONSEQ with HSEL=0000_0100 and slave 2 giving HRDATA=0xA5A5A5A5, HREADYOUT=1 -> next cycle HRDATA=0xA5A5A5A5, HRESP=00, HREADY=1.
REQ-033 SHALL cover: slave 5 selected with HREADYOUT_S[5] low for 3 cycles while HSEL changes to slave 1 -> HREADY=0 for 3 cycles, selection stays 5, and slave 1 data appears only after the release.
REQ-034 SHALL cover: NONSEQ with HSEL=0 -> cycle1 HREADY=0/HRESP=01, cycle2 HREADY=1/HRESP=01, cycle3 OKAY; and a back-to-back unmapped NONSEQ during cycle2 -> the ERR1/ERR2 pair repeats.
REQ-035 SHALL cover: NONSEQ with HSEL=0001_0010 -> MSEL_ERR=1 for one cycle, a two-cycle ERROR response, and no slave data on HRDATA.
REQ-036 SHALL cover: IDLE and BUSY with HSEL=0000_0001 -> HREADY=1, HRESP=00 and HRDATA=0 while slave 0 data is ignored.
REQ-037 SHALL cover: HRESETn pulsed low during DS_ERR1 -> outputs immediately HREADY=1, HRESP=00 and HRDATA=0, with normal operation after release.
REQ-038 SHALL repeat the directed scenarios at NSLV=1, NSLV=16 and DW=64.
